// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encodings and widths for the memory arbiter
package mem_arbiter_pkg;

  localparam int CNT_W  = 4;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_I = 2'b01,
    ST_BUSY_D = 2'b10
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data requester and unified memory signal bundle
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic              d_req;
  logic              d_wr;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_en;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              stall_if;
  logic              stall_d;
  logic              err;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, if_done, if_rdata,
           d_done, d_rdata, stall_if, stall_d, err
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, if_done, if_rdata,
           d_done, d_rdata, stall_if, stall_d, err
  );

endinterface

// File: rtl/mem_arbiter_lat_counter.sv
// rtl/mem_arbiter_lat_counter.sv - loadable down-counter with zero flag
module lat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Saturates at zero so an idle counter keeps reporting zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - data-priority arbiter between fetch and data stage for a
// fixed-latency single-port memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_load;
  logic              w_zero;
  logic              w_d_elig;
  logic              w_i_elig;
  logic              w_misal;

  logic              r_mem_en;
  logic              r_mem_wr;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_done;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_d_done;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_err;

  // A requester's own done cycle still shows its stale level-held request.
  assign w_d_elig = bus.d_req  & ~r_d_done;
  assign w_i_elig = bus.if_req & ~r_if_done;
  assign w_misal  = r_mem_addr[0];

  lat_counter #(.WIDTH(CNT_W)) u_lat (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (CNT_W'(LATENCY)),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_d_elig) begin
          w_next    = ST_BUSY_D;
          w_grant_d = 1'b1;
        end else if (w_i_elig) begin
          w_next    = ST_BUSY_I;
          w_grant_i = 1'b1;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (w_zero) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    w_load = w_grant_d | w_grant_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_done   <= 1'b0;
      r_if_rdata  <= '0;
      r_d_done    <= 1'b0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_mem_en  <= 1'b0;
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_err     <= 1'b0;
      if (w_grant_d) begin
        r_mem_addr  <= bus.d_addr;
        r_mem_wr    <= bus.d_wr;
        r_mem_wdata <= bus.d_wdata;
        r_mem_en    <= ~bus.d_addr[0];
      end else if (w_grant_i) begin
        r_mem_addr <= bus.if_addr;
        r_mem_wr   <= 1'b0;
        r_mem_en   <= ~bus.if_addr[0];
      end else if (w_zero && r_state == ST_BUSY_I) begin
        r_if_done  <= 1'b1;
        r_err      <= w_misal;
        r_if_rdata <= w_misal ? '0 : bus.mem_rdata;
      end else if (w_zero && r_state == ST_BUSY_D) begin
        r_d_done <= 1'b1;
        r_err    <= w_misal;
        if (w_misal) begin
          r_d_rdata <= '0;
        end else if (!r_mem_wr) begin
          r_d_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_done   = r_if_done;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_done    = r_d_done;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.err       = r_err;
  assign bus.stall_if  = bus.if_req & ~r_if_done;
  assign bus.stall_d   = bus.d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter with LATENCY=2
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_data_val;
  logic        en_d1, en_d2;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          if_keep = 0;

  logic        log_en[64], log_ifd[64], log_dd[64], log_err[64];
  logic        log_sif[64], log_sd[64], log_wr[64];
  logic [15:0] log_wdata[64];

  mem_arbiter_if bus();

  mem_arbiter #(.LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory answers exactly two cycles after a strobe; garbage otherwise.
  always_ff @(posedge clk) begin
    en_d1 <= bus.mem_en;
    en_d2 <= en_d1;
  end
  assign bus.mem_rdata = en_d2 ? mem_data_val : 16'hDEAD;

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mem_val;
    int          done_cyc;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          en_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Entered at posedge+1 with cycle-0 inputs applied; logs each cycle.
  task automatic run(input int n);
    for (int c = 0; c < 64; c++) begin
      log_en[c] = 0; log_ifd[c] = 0; log_dd[c] = 0; log_err[c] = 0;
      log_sif[c] = 0; log_sd[c] = 0; log_wr[c] = 0; log_wdata[c] = 0;
    end
    for (int c = 0; c < n; c++) begin
      #1;
      log_en[c]    = bus.mem_en;
      log_ifd[c]   = bus.if_done;
      log_dd[c]    = bus.d_done;
      log_err[c]   = bus.err;
      log_sif[c]   = bus.stall_if;
      log_sd[c]    = bus.stall_d;
      log_wr[c]    = bus.mem_wr;
      log_wdata[c] = bus.mem_wdata;
      @(posedge clk); #1;
      if (log_ifd[c]) begin
        if (if_keep > 0) if_keep--;
        else bus.if_req = 1'b0;
      end
      if (log_dd[c]) bus.d_req = 1'b0;
    end
  endtask

  function automatic int first_ev(input int sel, input int from);
    logic v;
    for (int c = from; c < 64; c++) begin
      case (sel)
        0:       v = log_en[c];
        1:       v = log_ifd[c];
        default: v = log_dd[c];
      endcase
      if (v === 1'b1) return c;
    end
    return -1;
  endfunction

  function automatic int count_ev(input int sel, input int from, input int to);
    int n = 0;
    for (int c = from; c < to; c++) begin
      case (sel)
        0:       n += (log_en[c] === 1'b1) ? 1 : 0;
        1:       n += (log_ifd[c] === 1'b1) ? 1 : 0;
        default: n += (log_dd[c] === 1'b1) ? 1 : 0;
      endcase
    end
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dn;
    vec_t v;

    //            is_d wr  addr      wdata     mem_val   done rdata     err en
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 4, 16'hBEEF, 1'b0, 1};
    vecs[1] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5A5A, 4, 16'h5A5A, 1'b0, 1};
    vecs[2] = '{1'b1, 1'b1, 16'h0300, 16'h1234, 16'hFFFF, 4, 16'h5A5A, 1'b0, 1};
    vecs[3] = '{1'b1, 1'b0, 16'h0201, 16'h0000, 16'h7777, 4, 16'h0000, 1'b1, 0};
    vecs[4] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h1111, 4, 16'h0000, 1'b1, 0};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0001, 4, 16'h0001, 1'b0, 1};

    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_wr = 0;
    bus.d_addr = 0; bus.d_wdata = 0; mem_data_val = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_strobes", {bus.mem_en, bus.mem_wr, bus.if_done, bus.d_done, bus.err,
                          bus.stall_if, bus.stall_d}, 0);
    chk("reset_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 0);
    chk("reset_rdata", {bus.if_rdata, bus.d_rdata}, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      mem_data_val = v.mem_val;
      if (v.is_d) begin
        bus.d_req = 1; bus.d_wr = v.wr; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
      end else begin
        bus.if_req = 1; bus.if_addr = v.addr;
      end
      run(8);
      dn = first_ev(v.is_d ? 2 : 1, 0);
      chk($sformatf("v%0d_done_cyc", i), dn, v.done_cyc);
      chk($sformatf("v%0d_other_done", i), count_ev(v.is_d ? 1 : 2, 0, 8), 0);
      chk($sformatf("v%0d_en_cnt", i), count_ev(0, 0, 8), v.en_cnt);
      if (v.en_cnt == 1) chk($sformatf("v%0d_en_cyc", i), first_ev(0, 0), 1);
      chk($sformatf("v%0d_rdata", i), v.is_d ? bus.d_rdata : bus.if_rdata, v.exp_rdata);
      chk($sformatf("v%0d_err", i), (dn >= 0) ? log_err[dn] : 1'bx, v.exp_err);
      chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, v.addr);
      chk($sformatf("v%0d_mem_wr", i), bus.mem_wr, v.is_d ? v.wr : 1'b0);
      if (v.wr) chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, v.wdata);
      chk($sformatf("v%0d_stall_c3", i), v.is_d ? log_sd[3] : log_sif[3], 1'b1);
      chk($sformatf("v%0d_stall_c4", i), v.is_d ? log_sd[4] : log_sif[4], 1'b0);
    end

    // Simultaneous store and fetch: data wins, fetch granted in d_done cycle.
    mem_data_val = 16'hCAFE;
    bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0200; bus.d_wdata = 16'h1234;
    bus.if_req = 1; bus.if_addr = 16'h0010;
    run(12);
    chk("sim_store_en", first_ev(0, 0), 1);
    chk("sim_store_wr", log_wr[1], 1'b1);
    chk("sim_store_wdata", log_wdata[1], 16'h1234);
    chk("sim_d_done", first_ev(2, 0), 4);
    chk("sim_fetch_en", first_ev(0, 2), 5);
    chk("sim_fetch_wr", log_wr[5], 1'b0);
    chk("sim_if_done", first_ev(1, 0), 8);
    chk("sim_if_rdata", bus.if_rdata, 16'hCAFE);
    chk("sim_stall_if_c7", log_sif[7], 1'b1);
    chk("sim_stall_if_c8", log_sif[8], 1'b0);

    // Fetch request held across its own done: no regrant in the done cycle.
    mem_data_val = 16'h2468;
    if_keep = 1;
    bus.if_req = 1; bus.if_addr = 16'h0040;
    run(14);
    chk("hold_first_done", first_ev(1, 0), 4);
    chk("hold_no_en_c5", log_en[5], 1'b0);
    chk("hold_second_en", first_ev(0, 2), 6);
    chk("hold_second_done", first_ev(1, 5), 9);
    chk("hold_en_cnt", count_ev(0, 0, 14), 2);
    chk("hold_stall_c4", log_sif[4], 1'b0);
    chk("hold_stall_c5", log_sif[5], 1'b1);
    chk("hold_rdata", bus.if_rdata, 16'h2468);

    // Reset in cycle 2 of a fetch abandons it.
    mem_data_val = 16'h1357;
    bus.if_req = 1; bus.if_addr = 16'h0050;
    #1;
    chk("rst_seq_en_c0", bus.mem_en, 1'b0);
    @(posedge clk); #1;
    #1;
    chk("rst_seq_en_c1", bus.mem_en, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_seq_no_done_c2", bus.if_done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_seq_c3_strobes", {bus.mem_en, bus.if_done, bus.err, bus.mem_wr}, 0);
    chk("rst_seq_c3_addr", bus.mem_addr, 16'h0000);
    chk("rst_seq_c3_if_rdata", bus.if_rdata, 16'h0000);
    run(8);
    chk("rst_seq_new_en", first_ev(0, 0), 1);
    chk("rst_seq_new_done", first_ev(1, 0), 4);
    chk("rst_seq_new_rdata", bus.if_rdata, 16'h1357);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
